// File: rtl/ex_conv_shad.sv
`default_nettype none
// ============================================================================
// Module   : ex_conv_shad
// Purpose  : Combinational SH-style conversion unit plus 32/64-bit SHAD/SHLD.
// Revision : 1.0 - initial release
// ============================================================================
module ex_conv_shad (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] valRs,
  input  logic [7:0]  valRt,
  input  logic [7:0]  convIxt,
  input  logic        srIn,
  input  logic        shOp,
  output logic [63:0] convOut,
  output logic        convSrT,
  output logic [31:0] shad32Out,
  output logic [63:0] shad64Out
);

  localparam logic [7:0] C_LIM32 = 8'd32;
  localparam logic [7:0] C_LIM64 = 8'd64;

  // clock/reset exist only for pipeline integration; nothing here is stateful.
  logic w_unused;
  assign w_unused = ^{clock, reset, convIxt[7:6]};

  logic [31:0] w_op32;
  logic [7:0]  w_negRt;
  assign w_op32  = valRs[31:0];
  // Magnitude of a negative count; -128 wraps to 0x80, which still compares as
  // "too large" and therefore lands in the saturating branch.
  assign w_negRt = ~valRt + 8'd1;

  always_comb begin
    convOut = valRs;
    convSrT = srIn;
    case (convIxt[5:0])
      6'h01: convOut = {56'd0, valRs[7:0]};
      6'h02: convOut = {48'd0, valRs[15:0]};
      6'h03: convOut = {32'd0, valRs[31:0]};
      6'h04: convOut = {{56{valRs[7]}}, valRs[7:0]};
      6'h05: convOut = {{48{valRs[15]}}, valRs[15:0]};
      6'h06: convOut = {{32{valRs[31]}}, valRs[31:0]};
      6'h07: convOut = ~valRs;
      6'h08: convOut = 64'd0 - valRs;
      6'h0A: begin
        convOut = {1'b0, valRs[63:1]};
        convSrT = valRs[0];
      end
      6'h0B: begin
        convOut = {valRs[63], valRs[63:1]};
        convSrT = valRs[0];
      end
      6'h0C: begin
        convOut = {valRs[62:0], srIn};
        convSrT = valRs[63];
      end
      6'h0D: begin
        convOut = {srIn, valRs[63:1]};
        convSrT = valRs[0];
      end
      default: begin
        convOut = valRs;
        convSrT = srIn;
      end
    endcase
  end

  always_comb begin
    shad32Out = 32'd0;
    if (!valRt[7]) begin
      if (valRt < C_LIM32) shad32Out = w_op32 << valRt[4:0];
    end else if (w_negRt < C_LIM32) begin
      if (shOp) shad32Out = w_op32 >> w_negRt[4:0];
      else      shad32Out = $signed(w_op32) >>> w_negRt[4:0];
    end else if (!shOp) begin
      shad32Out = {32{w_op32[31]}};
    end
  end

  always_comb begin
    shad64Out = 64'd0;
    if (!valRt[7]) begin
      if (valRt < C_LIM64) shad64Out = valRs << valRt[5:0];
    end else if (w_negRt < C_LIM64) begin
      if (shOp) shad64Out = valRs >> w_negRt[5:0];
      else      shad64Out = $signed(valRs) >>> w_negRt[5:0];
    end else if (!shOp) begin
      shad64Out = {64{valRs[63]}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_conv_shad.sv
`default_nettype none
// Scoreboarded random + directed bench for ex_conv_shad against a bitwise model.
module tb_ex_conv_shad;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] valRs = '0;
  logic [7:0]  valRt = '0;
  logic [7:0]  convIxt = '0;
  logic        srIn = 1'b0;
  logic        shOp = 1'b0;
  logic [63:0] convOut;
  logic        convSrT;
  logic [31:0] shad32Out;
  logic [63:0] shad64Out;

  ex_conv_shad dut (
    .clock(clock), .reset(reset), .valRs(valRs), .valRt(valRt),
    .convIxt(convIxt), .srIn(srIn), .shOp(shOp), .convOut(convOut),
    .convSrT(convSrT), .shad32Out(shad32Out), .shad64Out(shad64Out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] conv;
    logic        t;
    logic [31:0] s32;
    logic [63:0] s64;
  } exp_t;

  exp_t expQ[$];
  int   nTests = 0;
  int   nFail  = 0;
  bit   done   = 0;

  // Each result bit i comes from source bit (i - n); beyond the top it is the fill.
  function automatic logic [63:0] shiftModel(input logic [63:0] v, input int w,
                                             input int n, input logic logical);
    logic [63:0] r;
    logic fill;
    r = '0;
    fill = logical ? 1'b0 : v[w-1];
    for (int i = 0; i < w; i++) begin
      int j;
      j = i - n;
      if (j < 0)       r[i] = 1'b0;
      else if (j >= w) r[i] = fill;
      else             r[i] = v[j];
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [63:0] rs, input logic [7:0] rt,
                                 input logic [7:0] ix, input logic sr, input logic op);
    exp_t e;
    byte     b;
    shortint h;
    int      wd;
    int      n;
    b  = rs[7:0];
    h  = rs[15:0];
    wd = rs[31:0];
    e.conv = rs;
    e.t    = sr;
    case (ix & 8'h3F)
      8'h01: e.conv = 64'(rs[7:0]);
      8'h02: e.conv = 64'(rs[15:0]);
      8'h03: e.conv = 64'(rs[31:0]);
      8'h04: e.conv = longint'(b);
      8'h05: e.conv = longint'(h);
      8'h06: e.conv = longint'(wd);
      8'h07: e.conv = ~rs;
      8'h08: e.conv = 64'd0 - rs;
      8'h0A: begin e.conv = rs / 2; e.t = rs[0]; end
      8'h0B: begin e.conv = (rs / 2) | (rs & 64'h8000_0000_0000_0000); e.t = rs[0]; end
      8'h0C: begin e.conv = (rs * 2) + 64'(sr); e.t = rs[63]; end
      8'h0D: begin e.conv = (rs / 2) + (sr ? 64'h8000_0000_0000_0000 : 64'd0); e.t = rs[0]; end
      default: ;
    endcase
    n = int'($signed(rt));
    e.s64 = shiftModel(rs, 64, n, op);
    e.s32 = shiftModel({32'd0, rs[31:0]}, 32, n, op)[31:0];
    return e;
  endfunction

  task automatic drive(input logic [63:0] rs, input logic [7:0] rt, input logic [7:0] ix,
                       input logic sr, input logic op);
    @(posedge clock);
    #1;
    valRs = rs; valRt = rt; convIxt = ix; srIn = sr; shOp = op;
    expQ.push_back(model(rs, rt, ix, sr, op));
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (rs=%h rt=%h ix=%h sr=%b op=%b)",
               nm, got, want, valRs, valRt, convIxt, srIn, shOp);
    end
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("convOut",   convOut,           e.conv);
      check("convSrT",   64'(convSrT),      64'(e.t));
      check("shad32Out", 64'(shad32Out),    64'(e.s32));
      check("shad64Out", shad64Out,         e.s64);
    end
  end

  // Fixed-value checks straight from the worked examples.
  task automatic directConst(input string nm, input logic [63:0] got, input logic [63:0] want);
    check(nm, got, want);
  endtask

  initial begin
    logic [7:0] edges [10];
    edges = '{8'h80, 8'h81, 8'hC0, 8'hC1, 8'hE0, 8'hE1, 8'h1F, 8'h20, 8'h3F, 8'h40};

    // Reset state with all-zero inputs.
    drive(64'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("reset_conv", convOut, 64'd0);
    directConst("reset_s64", shad64Out, 64'd0);

    drive(64'h80, 8'd0, 8'h04, 1'b1, 1'b0);
    @(negedge clock); #1;
    directConst("exts_b", convOut, 64'hFFFF_FFFF_FFFF_FF80);
    drive(64'h80, 8'd0, 8'h01, 1'b0, 1'b0);
    drive(64'h8000_0000_0000_0001, 8'd0, 8'h0C, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("rotcl", convOut, 64'h2);
    directConst("rotcl_t", 64'(convSrT), 64'd1);
    drive(64'h8000_0000_0000_0001, 8'd0, 8'h0B, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("shar1", convOut, 64'hC000_0000_0000_0000);
    drive(64'h8000_0010, 8'hFC, 8'h00, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("shad32_neg4", 64'(shad32Out), 64'hF800_0001);
    drive(64'h8000_0010, 8'hFC, 8'h00, 1'b0, 1'b1);
    @(negedge clock); #1;
    directConst("shld32_neg4", 64'(shad32Out), 64'h0800_0001);
    drive(64'h8000_0010, 8'h04, 8'h00, 1'b0, 1'b0);
    drive(64'h8000_0000_0000_0000, 8'h80, 8'h00, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("shad64_m128", shad64Out, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(64'h8000_0000_0000_0000, 8'h40, 8'h00, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("shad64_64", shad64Out, 64'd0);
    drive(64'h8000_0000_0000_0000, 8'hC1, 8'h00, 1'b0, 1'b0);
    drive(64'd1, 8'd63, 8'h00, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("shad64_63", shad64Out, 64'h8000_0000_0000_0000);
    directConst("shad32_63", 64'(shad32Out), 64'd0);
    drive(64'd1, 8'd31, 8'h00, 1'b0, 1'b0);
    @(negedge clock); #1;
    directConst("shad32_31", 64'(shad32Out), 64'h8000_0000);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] rs;
      logic [7:0]  rt;
      if (i % 3 == 0) reset = ~reset;
      rs = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rs[63] = 1'b1;
      rt = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 9)] : 8'($urandom);
      drive(rs, rt, 8'($urandom_range(0, 15)) | (8'($urandom_range(0, 3)) << 6),
            1'($urandom), 1'($urandom));
    end

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clock);
    if (expQ.size() > 0) begin
      nTests++;
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire
